vga_fb_scanout: RTL and testbench

//  Consumer end of the pixel-plot interface driven by the VGA demos (VGA_X, VGA_Y, VGA_COLOR, plot).

---
 rtl/vga_fb_scanout.sv | 128 ++++++++++++
 tb/tb_vga_fb_scanout.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: on-chip framebuffer behind the VGA plot interface, cleared after reset and scanned out as a raster pixel stream
// Ports:
//   CLOCK_50, Resetn          clock, synchronous active-low reset
//   VGA_X, VGA_Y, VGA_COLOR   plot coordinates and colour, written when plot is high
//   busy                      high while the post-reset clear runs (plots ignored)
//   drop_count                saturating count of out-of-range plots
//   out_valid, out_ready      scan stream handshake
//   out_x, out_y, out_color   scanned pixel; out_sof marks pixel (0,0)
module vga_fb_scanout #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int COLS = 160,
  parameter int ROWS = 120,
  parameter int CW = 3,
  parameter logic [CW-1:0] CLEAR_COLOR = '0
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic [XW-1:0] VGA_X,
  input  logic [YW-1:0] VGA_Y,
  input  logic [CW-1:0] VGA_COLOR,
  input  logic          plot,
  output logic          busy,
  output logic [7:0]    drop_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic [CW-1:0] out_color,
  output logic          out_sof
);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW = $clog2(DEPTH);
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [AW-1:0] A_LAST = AW'(DEPTH - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] q, wd;
  logic [AW-1:0] clr_addr, wa, ra;
  logic we, re, pop, in_range, inflight;
  logic [XW-1:0] sx, rx;
  logic [YW-1:0] sy, ry;
  logic [XW-1:0] fx [2];
  logic [YW-1:0] fy [2];
  logic [CW-1:0] fc [2];
  logic [1:0] fs;
  logic wp, rp;
  logic [1:0] cnt;
  assign in_range = ({1'b0, VGA_X} < (XW+1)'(COLS)) && ({1'b0, VGA_Y} < (YW+1)'(ROWS));
  assign pop = out_valid && out_ready;
  assign out_valid = cnt != 2'd0;
  assign out_x = fx[rp];
  assign out_y = fy[rp];
  assign out_color = fc[rp];
  assign out_sof = fs[rp];
  assign ra = AW'(sy) * AW'(COLS) + AW'(sx);
  always_ff @(posedge CLOCK_50)
    state <= !Resetn ? CLEAR : state_nx;
  // A read may be issued whenever the skid buffer plus the read in flight
  // leaves room, counting the slot freed by a pop in this same cycle so a
  // continuously ready sink sees one pixel per cycle.
  always_comb begin
    state_nx = state;
    busy = 1'b1;
    we = Resetn;
    wa = clr_addr;
    wd = CLEAR_COLOR;
    re = 1'b0;
    if (state == RUN) begin
      busy = 1'b0;
      we = Resetn && plot && in_range;
      wa = AW'(VGA_Y) * AW'(COLS) + AW'(VGA_X);
      wd = VGA_COLOR;
      re = Resetn && (pop || cnt == 2'd0 || (cnt == 2'd1 && !inflight));
    end else if (clr_addr == A_LAST) begin
      state_nx = RUN;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      clr_addr <= '0;
      drop_count <= '0;
    end else begin
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (state == RUN && plot && !in_range && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end
  // Read-before-write: a same-address write lands after the read samples the old word.
  always_ff @(posedge CLOCK_50) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      sx <= '0;
      sy <= '0;
      rx <= '0;
      ry <= '0;
      inflight <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      fx <= '{default: '0};
      fy <= '{default: '0};
      fc <= '{default: '0};
      fs <= '0;
    end else begin
      inflight <= re;
      if (re) begin
        rx <= sx;
        ry <= sy;
        sx <= sx == X_LAST ? '0 : sx + 1'b1;
        if (sx == X_LAST) sy <= sy == Y_LAST ? '0 : sy + 1'b1;
      end
      if (inflight) begin
        fx[wp] <= rx;
        fy[wp] <= ry;
        fc[wp] <= q;
        fs[wp] <= rx == '0 && ry == '0;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_vga_fb_scanout.sv
// tb_vga_fb_scanout: scoreboard bench for vga_fb_scanout (160x120, 3-bit colour)
module tb_vga_fb_scanout;
  logic CLOCK_50 = 1'b0;
  logic Resetn, plot, out_ready, busy, out_valid, out_sof;
  logic [7:0] VGA_X, out_x, drop_count;
  logic [6:0] VGA_Y, out_y;
  logic [2:0] VGA_COLOR, out_color;
  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c; logic sof;} pix_t;
  pix_t sb [$];
  logic [2:0] model [19200];
  int total = 0, passes = 0, got = 0, exp_idx = 0, run_cyc = 0, drops = 0;
  bit held = 1'b0;
  logic [19:0] hold_val;
  always #5 CLOCK_50 = ~CLOCK_50;
  vga_fb_scanout dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .VGA_COLOR(VGA_COLOR), .plot(plot), .busy(busy), .drop_count(drop_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_color(out_color), .out_sof(out_sof)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Expected pixels are queued in raster order from the model at the moment the DUT reads them.
  task automatic push_upto(input int n);
    while (exp_idx < n) begin
      int i;
      i = exp_idx % 19200;
      sb.push_back({8'(i % 160), 7'(i / 160), model[i], i == 0});
      exp_idx++;
    end
  endtask
  task automatic reset_checks();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_drop", drop_count, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_color", out_color, 0);
    chk("rst_sof", out_sof, 0);
  endtask
  // Called at a negedge right after a reset edge; releases reset and times the clear.
  task automatic clear_phase();
    int n = 0;
    int vbad = 0;
    Resetn = 1'b1;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      vbad += int'(out_valid);
      plot = n > 19100 && n <= 19104;
      VGA_X = n[0] ? 8'd200 : 8'd0;
      VGA_Y = 7'd0;
      VGA_COLOR = 3'd6;
      @(negedge CLOCK_50);
    end
    plot = 1'b0;
    chk("busy_len", n, 19200);
    chk("clear_valid", vbad, 0);
    chk("clear_drop", drop_count, 0);
    foreach (model[i]) model[i] = '0;
    sb.delete();
    got = 0;
    exp_idx = 0;
    run_cyc = 0;
    held = 1'b0;
    drops = 0;
  endtask
  task automatic step(input bit rdy, input bit pl, input int x, input int y, input int c);
    pix_t e;
    bit inr;
    inr = x < 160 && y < 120;
    out_ready = rdy;
    plot = pl;
    VGA_X = 8'(x);
    VGA_Y = 7'(y);
    VGA_COLOR = 3'(c);
    if (held) chk("stall_hold", {out_valid, out_x, out_y, out_color, out_sof}, hold_val);
    if (run_cyc < 2) chk("first_valid_low", out_valid, 0);
    else chk("gapless", out_valid, 1);
    run_cyc++;
    held = out_valid && !rdy;
    hold_val = {out_valid, out_x, out_y, out_color, out_sof};
    push_upto(got + 2);
    if (out_valid && rdy) begin
      push_upto(got + 3);
      e = sb.pop_front();
      chk("pixel", {out_x, out_y, out_color, out_sof}, e);
      got++;
    end
    if (pl && inr) model[y * 160 + x] = 3'(c);
    if (pl && !inr && drops < 255) drops++;
    @(negedge CLOCK_50);
    if (pl && !inr) chk("drop_count", drop_count, drops);
  endtask
  task automatic drain(input int target, input bit rnd);
    int guard = 0;
    while (got < target && guard < 60000) begin
      guard++;
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 0, 0, 0);
    end
    chk("drain_reach", got, target);
  endtask
  initial begin
    Resetn = 1'b0;
    plot = 1'b0;
    VGA_X = '0;
    VGA_Y = '0;
    VGA_COLOR = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_checks();
    clear_phase();
    // First RUN cycle: the scan reads (0,0) on the same edge as this write.
    step(1'b0, 1'b1, 0, 0, 7);
    repeat (3) step(1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 5, 3, 5);
    step(1'b0, 1'b1, 160, 0, 1);
    step(1'b0, 1'b1, 0, 120, 2);
    for (int k = 0; k < 300; k++)
      step(1'b0, 1'b1,
           k % 2 ? 160 + int'($urandom_range(0, 95)) : int'($urandom_range(0, 159)),
           k % 2 ? int'($urandom_range(0, 127)) : 120 + int'($urandom_range(0, 7)),
           k % 8);
    drain(1000, 1'b1);
    drain(19200 + 60 * 160 + 80, 1'b0);
    chk("pre_rst_head", {out_x, out_y}, {8'd80, 7'd60});
    Resetn = 1'b0;
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    reset_checks();
    clear_phase();
    drain(500, 1'b0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
